kadai5: RTL and testbench
=========================

KADAI5 -- requirements
Module: kadai5

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set operand width in bits; legal range 2..16.
REQ-002 Parameter DEPTH, default 8, SHALL set pairs per batch; power of two, range 2..256.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 RST  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 A  input  DATA_W  SHALL be operand A, sampled on handshake.
REQ-006 B  input  DATA_W  SHALL be operand B, sampled on handshake.
REQ-007 ACK  input  1  SHALL qualify A/B as valid while REQ_AB is high.
REQ-008 START  input  1  SHALL start a batch when sampled high in IDLE.
REQ-009 HALT  input  1  SHALL abort any batch.
REQ-010 X_READY  input  1  SHALL indicate the consumer accepts X this cycle.
REQ-011 X  output  2*DATA_W  SHALL carry the unsigned product A*B of the current output beat.
REQ-012 X_VALID  output  1  SHALL mark X valid.
REQ-013 X_LAST  output  1  SHALL mark the final beat (DEPTH-th) of a batch.
REQ-014 REQ_AB  output  1  SHALL request operand pairs.
REQ-015 BUSY  output  1  SHALL be high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, INPUT, EXEC, OUTPUT.
REQ-017 IDLE->INPUT on START=1; REQ_AB SHALL be high from the next cycle; START outside IDLE SHALL be ignored.
REQ-018 In INPUT, a pair SHALL be captured at each edge with REQ_AB=1 and ACK=1; ACK low cycles SHALL capture nothing and hold REQ_AB high.
REQ-019 On the DEPTH-th capture edge the FSM SHALL enter EXEC and REQ_AB SHALL drop in the following cycle; no extra pair captured.
REQ-020 EXEC SHALL compute one product per cycle in capture order, lasting exactly DEPTH cycles, then enter OUTPUT.
REQ-021 In OUTPUT, X_VALID SHALL be high; a beat SHALL advance only on an edge with X_VALID=1 and X_READY=1; X SHALL hold stable while X_READY=0.
REQ-022 X_LAST SHALL be high only with the DEPTH-th beat; its acceptance SHALL return the FSM to IDLE and drop X_VALID next cycle.
REQ-023 Products SHALL be unsigned full-width; no truncation or saturation (e.g. 255*255=65025).
REQ-024 HALT=1 at an edge SHALL force IDLE from any state, clear all counters, and deassert REQ_AB, X_VALID, X_LAST next cycle; partial data SHALL be discarded.
REQ-025 HALT and START high together SHALL resolve to HALT (stay IDLE).
REQ-026 Counters SHALL be clog2(DEPTH)+1 bits wide and SHALL not wrap within a batch.

Reset
REQ-027 While RST=0: state IDLE; X=0, X_VALID=0, X_LAST=0, REQ_AB=0, BUSY=0, counters 0 (and SUM=0 if present).
REQ-028 RST deassertion mid-batch SHALL leave the block in IDLE awaiting START.

Configuration
REQ-029 Macro KADAI5_SUM_EN defined: output SUM (2*DATA_W+clog2(DEPTH) bits) SHALL hold the running sum of all products of the batch, final value valid with X_LAST, cleared on START/HALT.
REQ-030 Macro undefined: SUM port and accumulator SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package kadai5_pkg SHALL hold the state enum, default DATA_W/DEPTH constants and the counter-width function.
REQ-032 Operand and product storage SHALL be one sub-module kadai5_fifo (parametrised synchronous FIFO, width/depth parameters, clear input driven by HALT), instantiated for operands and for products.

Verification
REQ-033 A=1, B=1..8, ACK continuous -> X=1..8 over 8 beats, X_LAST on beat 8, BUSY low afterwards.
REQ-034 ACK low 4 cycles after 7th pair, then pair (1,8) -> REQ_AB high throughout gap, outputs 1..8, no duplicates.
REQ-035 HALT after 3 pairs (A=2) -> REQ_AB=0 next cycle, X_VALID never rises; next START with A=3,B=1..8 -> X=3,6..24.
REQ-036 HALT during EXEC, and during OUTPUT after 4 beats (A=4) -> X_VALID=0 next cycle, IDLE, no further beats.
REQ-037 A=4, B=1..8, X_READY low 3 cycles at beat 4 -> X=16 held stable 4 cycles, then 20..32.
REQ-038 A=B=255 all pairs -> every X=65025; with KADAI5_SUM_EN, SUM=520200 at X_LAST.

Source files
------------

// File: rtl/kadai5_pkg.sv
// Shared types and constants for the kadai5 batch multiplier.
package kadai5_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_INPUT  = 2'd1,
    S_EXEC   = 2'd2,
    S_OUTPUT = 2'd3
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;

  // One spare bit so a batch counter can reach DEPTH without wrapping.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/kadai5_fifo.sv
// Small synchronous FIFO with show-ahead read data and a synchronous clear.
module kadai5_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/kadai5.sv
// Batch multiplier: collect DEPTH operand pairs, multiply them, stream out products.
// Optional KADAI5_SUM_EN adds a SUM output holding the running sum of the batch.
// Handshakes: a pair moves on an edge with REQ_AB=1 and ACK=1; a product moves on an
// edge with X_VALID=1 and X_READY=1; X is held stable while X_READY=0.
module kadai5
  import kadai5_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [DATA_W-1:0]   A,
  input  logic [DATA_W-1:0]   B,
  input  logic                ACK,
  input  logic                START,
  input  logic                HALT,
  input  logic                X_READY,
  output logic [2*DATA_W-1:0] X,
  output logic                X_VALID,
  output logic                X_LAST,
  output logic                REQ_AB,
  output logic                BUSY,
`ifdef KADAI5_SUM_EN
  output logic [2*DATA_W+$clog2(DEPTH)-1:0] SUM,
`endif
  output state_e              dbg_state
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = 2 * DATA_W;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          cap_en, exec_en, beat_en;
  logic [PW-1:0] op_rd;
  logic [PW-1:0] prod;
  logic [PW-1:0] prod_rd;

  assign cap_en  = (state_q == S_INPUT)  && ACK;
  assign exec_en = (state_q == S_EXEC);
  assign beat_en = (state_q == S_OUTPUT) && X_READY;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (HALT) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            state_d = S_INPUT;
            cnt_d   = '0;
          end
        end
        S_INPUT: begin
          if (ACK) begin
            if (cnt_q == CNT_LAST) begin
              state_d = S_EXEC;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        S_EXEC: begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_OUTPUT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_OUTPUT: begin
          if (X_READY) begin
            if (cnt_q == CNT_LAST) begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  kadai5_fifo #(.W(PW), .DEPTH(DEPTH)) u_op_fifo (
    .clk     (CLK),
    .rst_n   (RST),
    .clr     (HALT),
    .wr_en   (cap_en),
    .wr_data ({A, B}),
    .rd_en   (exec_en),
    .rd_data (op_rd)
  );

  // Zero-extend before multiplying so the full 2*DATA_W product is kept.
  assign prod = PW'(op_rd[PW-1:DATA_W]) * PW'(op_rd[DATA_W-1:0]);

  kadai5_fifo #(.W(PW), .DEPTH(DEPTH)) u_prod_fifo (
    .clk     (CLK),
    .rst_n   (RST),
    .clr     (HALT),
    .wr_en   (exec_en),
    .wr_data (prod),
    .rd_en   (beat_en),
    .rd_data (prod_rd)
  );

`ifdef KADAI5_SUM_EN
  localparam int SW = 2 * DATA_W + $clog2(DEPTH);
  logic [SW-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (HALT || (state_q == S_IDLE && START)) sum_d = '0;
    else if (exec_en)                         sum_d = sum_q + SW'(prod);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sum_q <= '0;
    else      sum_q <= sum_d;
  end

  assign SUM = sum_q;
`endif

  assign X_VALID   = (state_q == S_OUTPUT);
  assign X_LAST    = X_VALID && (cnt_q == CNT_LAST);
  assign X         = X_VALID ? prod_rd : '0;
  assign REQ_AB    = (state_q == S_INPUT);
  assign BUSY      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_kadai5.sv
// Self-checking bench for kadai5: directed batches plus random traffic against a
// cycle-timeline reference model kept in terms of pairs captured and beats delivered.
module tb_kadai5;
  import kadai5_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int PW    = 2 * DW;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] A = '0, B = '0;
  logic          ACK = 1'b0, START = 1'b0, HALT = 1'b0, X_READY = 1'b0;
  logic [PW-1:0] X;
  logic          X_VALID, X_LAST, REQ_AB, BUSY;
  state_e        dbg_state;
`ifdef KADAI5_SUM_EN
  logic [PW+$clog2(DEPTH)-1:0] SUM;
`endif

  kadai5 #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A),
    .B         (B),
    .ACK       (ACK),
    .START     (START),
    .HALT      (HALT),
    .X_READY   (X_READY),
    .X         (X),
    .X_VALID   (X_VALID),
    .X_LAST    (X_LAST),
    .REQ_AB    (REQ_AB),
    .BUSY      (BUSY),
`ifdef KADAI5_SUM_EN
    .SUM       (SUM),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- checker ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  bit            m_active = 0;
  int            n_cap = 0, n_exec = 0, n_out = 0;
  longint        m_sum = 0;
  bit            exp_v;
  logic [PW-1:0] p;

  always @(negedge CLK) begin
    if (!RST) begin
      chk("rst_busy",    64'(BUSY),    0);
      chk("rst_x",       64'(X),       0);
      chk("rst_x_valid", 64'(X_VALID), 0);
      chk("rst_x_last",  64'(X_LAST),  0);
      chk("rst_req_ab",  64'(REQ_AB),  0);
`ifdef KADAI5_SUM_EN
      chk("rst_sum",     64'(SUM),     0);
`endif
      m_active = 0; n_cap = 0; n_exec = 0; n_out = 0; m_sum = 0;
      exp_q.delete();
    end else begin
      exp_v = m_active && n_cap == DEPTH && n_exec == DEPTH;
      chk("busy",    64'(BUSY),    64'(m_active));
      chk("req_ab",  64'(REQ_AB),  64'(m_active && n_cap < DEPTH));
      chk("x_valid", 64'(X_VALID), 64'(exp_v));
      if (exp_v) begin
        chk("x",      64'(X),      64'(exp_q[0]));
        chk("x_last", 64'(X_LAST), 64'(n_out == DEPTH - 1));
`ifdef KADAI5_SUM_EN
        if (n_out == DEPTH - 1) chk("sum", 64'(SUM), 64'(m_sum));
`endif
      end else begin
        chk("x_last_idle", 64'(X_LAST), 0);
      end
      // what the coming rising edge does
      if (HALT) begin
        m_active = 0; n_cap = 0; n_exec = 0; n_out = 0; m_sum = 0;
        exp_q.delete();
      end else if (!m_active) begin
        if (START) begin
          m_active = 1; n_cap = 0; n_exec = 0; n_out = 0; m_sum = 0;
          exp_q.delete();
        end
      end else if (n_cap < DEPTH) begin
        if (ACK) begin
          p = PW'(A) * PW'(B);
          exp_q.push_back(p);
          m_sum += longint'(p);
          n_cap++;
        end
      end else if (n_exec < DEPTH) begin
        n_exec++;
      end else if (X_READY) begin
        void'(exp_q.pop_front());
        n_out++;
        if (n_out == DEPTH) m_active = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic start_batch();
    START = 1'b1;
    cyc(1);
    START = 1'b0;
  endtask

  task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
    A = a; B = b; ACK = 1'b1;
    cyc(1);
    ACK = 1'b0;
  endtask

  task automatic send_batch(input logic [DW-1:0] a);
    for (int i = 1; i <= DEPTH; i++) send_pair(a, DW'(i));
  endtask

  task automatic halt_pulse();
    HALT = 1'b1;
    cyc(1);
    HALT = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k;
    k = 0;
    while (!X_VALID && k < budget) begin
      cyc(1);
      k++;
    end
    if (!X_VALID) chk(tag, 0, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (BUSY && k < budget) begin
      cyc(1);
      k++;
    end
    if (BUSY) chk(tag, 1, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cyc(3);
    RST = 1'b1;
    cyc(2);

    // basic batch, continuous ACK
    X_READY = 1'b1;
    start_batch();
    send_batch(8'd1);
    wait_idle("t_basic_timeout", 60);
    cyc(2);

    // ACK gap after the 7th pair, START pulsed during INPUT is ignored
    start_batch();
    for (int i = 1; i <= 7; i++) send_pair(8'd1, DW'(i));
    START = 1'b1;
    cyc(4);
    START = 1'b0;
    send_pair(8'd1, 8'd8);
    wait_idle("t_gap_timeout", 60);
    cyc(2);

    // HALT during INPUT, then a clean batch
    start_batch();
    for (int i = 1; i <= 3; i++) send_pair(8'd2, DW'(i));
    halt_pulse();
    cyc(20);
    start_batch();
    send_batch(8'd3);
    wait_idle("t_after_halt_timeout", 60);
    cyc(2);

    // HALT during EXEC
    start_batch();
    send_batch(8'd4);
    cyc(3);
    halt_pulse();
    cyc(20);

    // HALT during OUTPUT after 4 beats
    start_batch();
    send_batch(8'd4);
    wait_valid("t_out_halt_valid_timeout", 30);
    cyc(4);
    X_READY = 1'b0;
    halt_pulse();
    cyc(20);

    // consumer stall at beat 4
    X_READY = 1'b1;
    start_batch();
    send_batch(8'd4);
    wait_valid("t_stall_valid_timeout", 30);
    cyc(3);
    X_READY = 1'b0;
    cyc(3);
    X_READY = 1'b1;
    wait_idle("t_stall_timeout", 60);
    cyc(2);

    // full-scale operands
    start_batch();
    for (int i = 0; i < DEPTH; i++) send_pair(8'd255, 8'd255);
    wait_idle("t_max_timeout", 60);
    cyc(2);

    // HALT and START together stay idle
    HALT = 1'b1; START = 1'b1;
    cyc(1);
    HALT = 1'b0; START = 1'b0;
    cyc(3);

    // reset in mid-batch, then a normal batch
    start_batch();
    for (int i = 1; i <= 5; i++) send_pair(8'd7, DW'(i));
    RST = 1'b0;
    cyc(2);
    RST = 1'b1;
    cyc(3);
    start_batch();
    send_batch(8'd1);
    wait_idle("t_post_reset_timeout", 60);
    cyc(2);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      A       = DW'($urandom_range(0, 255));
      B       = DW'($urandom_range(0, 255));
      ACK     = ($urandom_range(0, 99) < 70);
      X_READY = ($urandom_range(0, 99) < 70);
      START   = ($urandom_range(0, 99) < 20);
      HALT    = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    ACK = 1'b0; START = 1'b0; HALT = 1'b0; X_READY = 1'b1;
    wait_idle("t_random_drain_timeout", 100);
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
